fifo_nto1_sync: RTL and testbench



---
 rtl/fifo_nto1_if.sv | 32 +++
 rtl/fifo_nto1_sync.sv | 95 +++++++++
 tb/tb_fifo_nto1_sync.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fifo_nto1_if.sv
// fifo_nto1_if: write/read bus of the N-to-1 width-converting FIFO
// master drives requests and write data; slave (the FIFO) drives data, flags and count.
interface fifo_nto1_if #(
  parameter int DSIZE = 8,
  parameter int NSIZE = 4,
  parameter int DEPTH = 8
);
  localparam int CAP = DEPTH * NSIZE;
  localparam int NW = $clog2(NSIZE + 1);
  localparam int CW = $clog2(CAP + 1);
  logic wr_en;
  logic [NW-1:0] wr_num;
  logic [DSIZE*NSIZE-1:0] wr_data;
  logic wr_full;
  logic wr_almost_full;
  logic rd_en;
  logic [DSIZE-1:0] rd_data;
  logic rd_vld;
  logic rd_empty;
  logic rd_almost_empty;
  logic [CW-1:0] count;
  logic overflow;
  logic underflow;
  modport master (
    output wr_en, wr_num, wr_data, rd_en,
    input wr_full, wr_almost_full, rd_data, rd_vld, rd_empty, rd_almost_empty, count, overflow, underflow
  );
  modport slave (
    input wr_en, wr_num, wr_data, rd_en,
    output wr_full, wr_almost_full, rd_data, rd_vld, rd_empty, rd_almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_nto1_sync.sv
// fifo_nto1_sync: single-clock FIFO taking up to NSIZE lanes per write, draining one element per read
// Ports: clk, rst (sync, active-high), bus (fifo_nto1_if.slave: wr_en/wr_num/wr_data in,
// wr_full/wr_almost_full out, rd_en in, rd_data/rd_vld/rd_empty/rd_almost_empty out, count, overflow, underflow).
// FIFO_NTO1_SYNC_FWFT_EN: first-word-fall-through read side; default is 1-cycle registered read.
module fifo_nto1_sync #(
  parameter int DSIZE = 8,
  parameter int NSIZE = 4,
  parameter int DEPTH = 8,
  parameter int ALMOST = 2,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0
) (
  input logic clk,
  input logic rst,
  fifo_nto1_if.slave bus
);
  localparam int CAP = DEPTH * NSIZE;
  localparam int NW = $clog2(NSIZE + 1);
  localparam int CW = $clog2(CAP + 1);
  localparam int AW = CAP > 1 ? $clog2(CAP) : 1;
  localparam logic [CW-1:0] FULL_T = CW'(CAP - NSIZE);
  localparam logic [CW-1:0] AF_T = CW'(CAP - ALMOST);
  localparam logic [CW-1:0] AE_T = CW'(ALMOST);
  logic [DSIZE-1:0] mem [CAP];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [AW-1:0] wa [NSIZE];
  logic [CW-1:0] cnt, cnt_nx;
  logic [NW-1:0] num;
  logic wr_acc, rd_acc, full, aful, empty, aempty, ovf, unf;
  // pointer + offset modulo CAP; offset never exceeds CAP so one subtraction suffices
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p, input logic [AW:0] n);
    logic [AW:0] s;
    s = {1'b0, p} + n;
    return s >= (AW+1)'(CAP) ? AW'(s - (AW+1)'(CAP)) : AW'(s);
  endfunction
  always_comb begin
    num = bus.wr_num > NW'(NSIZE) ? NW'(NSIZE) : bus.wr_num;
    wr_acc = bus.wr_en && !full;
    rd_acc = bus.rd_en && !empty;
    cnt_nx = cnt + (wr_acc ? CW'(num) : CW'(0)) - CW'(rd_acc);
    wr_ptr_nx = wr_acc ? wrap(wr_ptr, (AW+1)'(num)) : wr_ptr;
    rd_ptr_nx = rd_acc ? wrap(rd_ptr, (AW+1)'(1)) : rd_ptr;
    for (int i = 0; i < NSIZE; i++) wa[i] = wrap(wr_ptr, (AW+1)'(i));
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NSIZE; i++)
      if (!rst && wr_acc && i < int'(num)) mem[wa[i]] <= bus.wr_data[DSIZE*(NSIZE-1-i) +: DSIZE];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      empty <= 1'b1;
      aempty <= 1'b1;
      full <= 1'b0;
      aful <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      cnt <= cnt_nx;
      empty <= cnt_nx == '0;
      aempty <= cnt_nx <= AE_T;
      full <= cnt_nx > FULL_T;
      aful <= cnt_nx >= AF_T;
      ovf <= ovf | (bus.wr_en & full);
      unf <= unf | (bus.rd_en & empty);
    end
  end
`ifdef FIFO_NTO1_SYNC_FWFT_EN
  assign bus.rd_data = empty ? DEF_VALUE : mem[rd_ptr];
  assign bus.rd_vld = !empty;
`else
  logic [DSIZE-1:0] rdq;
  logic vld;
  always_ff @(posedge clk) begin
    if (rst) begin
      rdq <= DEF_VALUE;
      vld <= 1'b0;
    end else begin
      vld <= rd_acc;
      if (rd_acc) rdq <= mem[rd_ptr];
    end
  end
  assign bus.rd_data = rdq;
  assign bus.rd_vld = vld;
`endif
  assign bus.wr_full = full;
  assign bus.wr_almost_full = aful;
  assign bus.rd_empty = empty;
  assign bus.rd_almost_empty = aempty;
  assign bus.count = cnt;
  assign bus.overflow = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_fifo_nto1_sync.sv
// tb_fifo_nto1_sync: directed checks of fifo_nto1_sync (CAP=32 instance and CAP=9 wrap instance)
module tb_fifo_nto1_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fifo_nto1_if #(.DSIZE(8), .NSIZE(4), .DEPTH(8)) ia ();
  fifo_nto1_if #(.DSIZE(8), .NSIZE(3), .DEPTH(3)) ib ();
  fifo_nto1_sync #(.DSIZE(8), .NSIZE(4), .DEPTH(8), .ALMOST(2), .DEF_VALUE(8'h00)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fifo_nto1_sync #(.DSIZE(8), .NSIZE(3), .DEPTH(3), .ALMOST(2), .DEF_VALUE(8'h00)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_a(input logic [2:0] n, input logic [31:0] d);
    ia.wr_en = 1'b1;
    ia.wr_num = n;
    ia.wr_data = d;
    step();
    ia.wr_en = 1'b0;
  endtask
  task automatic rd_a(input logic [7:0] exp);
`ifdef FIFO_NTO1_SYNC_FWFT_EN
    check("a_rd_vld", ia.rd_vld, 1);
    check("a_rd_data", ia.rd_data, exp);
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
`else
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
    check("a_rd_vld", ia.rd_vld, 1);
    check("a_rd_data", ia.rd_data, exp);
`endif
  endtask
  task automatic rd_b(input logic [7:0] exp);
`ifdef FIFO_NTO1_SYNC_FWFT_EN
    check("b_rd_data", ib.rd_data, exp);
    ib.rd_en = 1'b1;
    step();
    ib.rd_en = 1'b0;
`else
    ib.rd_en = 1'b1;
    step();
    ib.rd_en = 1'b0;
    check("b_rd_data", ib.rd_data, exp);
`endif
  endtask
  task automatic flags_b(input string tag, input int c);
    check({tag, "_count"}, ib.count, c);
    check({tag, "_full"}, ib.wr_full, c > 6);
    check({tag, "_afull"}, ib.wr_almost_full, c >= 7);
    check({tag, "_aempty"}, ib.rd_almost_empty, c <= 2);
    check({tag, "_empty"}, ib.rd_empty, c == 0);
  endtask
  int nb[20] = '{3, 3, 1, 2, 0, 3, 1, 2, 3, 2, 1, 3, 0, 2, 3, 1, 3, 2, 2, 1};
  int rb[20] = '{1, 0, 0, 2, 1, 0, 3, 2, 1, 0, 2, 3, 1, 0, 2, 4, 2, 1, 3, 9};
  logic [7:0] q[$];
  logic [7:0] v = 8'h00;
  initial begin
    ia.wr_en = 1'b0; ia.wr_num = '0; ia.wr_data = '0; ia.rd_en = 1'b0;
    ib.wr_en = 1'b0; ib.wr_num = '0; ib.wr_data = '0; ib.rd_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_count", ia.count, 0);
    check("rst_empty", ia.rd_empty, 1);
    check("rst_aempty", ia.rd_almost_empty, 1);
    check("rst_full", ia.wr_full, 0);
    check("rst_afull", ia.wr_almost_full, 0);
    check("rst_vld", ia.rd_vld, 0);
    check("rst_data", ia.rd_data, 8'h00);
    check("rst_ovf", ia.overflow, 0);
    check("rst_unf", ia.underflow, 0);
    wr_a(3'd4, 32'h11223344);
    check("w4_count", ia.count, 4);
    check("w4_empty", ia.rd_empty, 0);
    check("w4_aempty", ia.rd_almost_empty, 0);
    rd_a(8'h11); rd_a(8'h22); rd_a(8'h33); rd_a(8'h44);
    check("r4_count", ia.count, 0);
    check("r4_empty", ia.rd_empty, 1);
    step();
    check("idle_vld", ia.rd_vld, 0);
`ifdef FIFO_NTO1_SYNC_FWFT_EN
    check("idle_data", ia.rd_data, 8'h00);
`else
    check("idle_hold", ia.rd_data, 8'h44);
`endif
    wr_a(3'd3, 32'hAABBCC00);
    wr_a(3'd1, 32'hDD000000);
    wr_a(3'd0, 32'h99999999);
    wr_a(3'd2, 32'hEEFF0000);
    check("mix_count", ia.count, 6);
    rd_a(8'hAA); rd_a(8'hBB); rd_a(8'hCC); rd_a(8'hDD); rd_a(8'hEE); rd_a(8'hFF);
    check("mix_count0", ia.count, 0);
    for (int k = 0; k < 7; k++) wr_a(3'd4, {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    check("f28_count", ia.count, 28);
    check("f28_full", ia.wr_full, 0);
    check("f28_afull", ia.wr_almost_full, 0);
    wr_a(3'd4, 32'h1C1D1E1F);
    check("f32_count", ia.count, 32);
    check("f32_full", ia.wr_full, 1);
    check("f32_afull", ia.wr_almost_full, 1);
    check("f32_ovf", ia.overflow, 0);
    wr_a(3'd4, 32'hDEADBEEF);
    check("ovf_count", ia.count, 32);
    check("ovf_flag", ia.overflow, 1);
    for (int k = 0; k < 32; k++) rd_a(8'(k));
    check("drain_count", ia.count, 0);
    check("drain_unf", ia.underflow, 0);
    wr_a(3'd4, 32'h01020304);
    wr_a(3'd1, 32'h05000000);
    check("sim_pre", ia.count, 5);
`ifdef FIFO_NTO1_SYNC_FWFT_EN
    check("sim_head", ia.rd_data, 8'h01);
`endif
    ia.wr_en = 1'b1; ia.wr_num = 3'd4; ia.wr_data = 32'h06070809; ia.rd_en = 1'b1;
    step();
    ia.wr_en = 1'b0; ia.rd_en = 1'b0;
    check("sim_count", ia.count, 8);
`ifndef FIFO_NTO1_SYNC_FWFT_EN
    check("sim_vld", ia.rd_vld, 1);
    check("sim_data", ia.rd_data, 8'h01);
`endif
    for (int k = 2; k <= 9; k++) rd_a(8'(k));
    ia.rd_en = 1'b1;
    step();
    ia.rd_en = 1'b0;
    check("unf_flag", ia.underflow, 1);
    check("unf_vld", ia.rd_vld, 0);
    check("unf_count", ia.count, 0);
    wr_a(3'd7, 32'h61626364);
    check("clamp_count", ia.count, 4);
    rd_a(8'h61);
    ia.wr_en = 1'b1; ia.wr_num = 3'd4; ia.wr_data = 32'h71727374; ia.rd_en = 1'b1; rst = 1'b1;
    step();
    ia.wr_en = 1'b0; ia.rd_en = 1'b0; rst = 1'b0;
    check("mrst_count", ia.count, 0);
    check("mrst_empty", ia.rd_empty, 1);
    check("mrst_vld", ia.rd_vld, 0);
    check("mrst_data", ia.rd_data, 8'h00);
    check("mrst_ovf", ia.overflow, 0);
    check("mrst_unf", ia.underflow, 0);
    wr_a(3'd2, 32'h5A6B0000);
    rd_a(8'h5A);
    rd_a(8'h6B);
    flags_b("b_init", 0);
    for (int it = 0; it < 20; it++) begin
      if (q.size() <= 6) begin
        ib.wr_en = 1'b1;
        ib.wr_num = 2'(nb[it]);
        ib.wr_data = {v, v + 8'd1, v + 8'd2};
        step();
        ib.wr_en = 1'b0;
        for (int k = 0; k < nb[it]; k++) q.push_back(v + 8'(k));
        v = v + 8'(nb[it]);
        flags_b("b_wr", q.size());
      end
      for (int k = 0; k < rb[it] && q.size() > 0; k++) begin
        rd_b(q.pop_front());
        flags_b("b_rd", q.size());
      end
    end
    check("b_ovf", ib.overflow, 0);
    check("b_unf", ib.underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
